// File: rtl/ad_dual_capture.sv
// Dual 10-bit ADC front-end: sequences output-enables through warm-up and pipeline flush,
// captures both channels with aligned OTR flags, decimates, and counts OTR events.
module ad_dual_capture #(
    parameter int DW         = 10,
    parameter int WARMUP_CYC = 200,
    parameter int FLUSH_CYC  = 6,
    parameter int DECIM_W    = 8,
    parameter int OTR_CNT_W  = 16
) (
    input  logic                 clk_20M,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DECIM_W-1:0]   decim,
    input  logic                 otr_clr,
    input  logic [DW-1:0]        adc1_pin,
    input  logic [DW-1:0]        adc2_pin,
    input  logic                 otr1_pin,
    input  logic                 otr2_pin,
    output logic                 ad1oe,
    output logic                 ad2oe,
    output logic [DW-1:0]        ad_data1,
    output logic [DW-1:0]        ad_data2,
    output logic                 OTR1,
    output logic                 OTR2,
    output logic                 data_valid,
    output logic                 ready,
    output logic [OTR_CNT_W-1:0] otr1_cnt,
    output logic [OTR_CNT_W-1:0] otr2_cnt
);

    localparam int CNT_MAX = (WARMUP_CYC > FLUSH_CYC) ? WARMUP_CYC : FLUSH_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP_CYC - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DECIM_W-1:0]   dcnt_q, dcnt_d;

    logic [DW-1:0]        adc1_r1_q, adc2_r1_q;
    logic                 otr1_r1_q, otr2_r1_q;

    logic                 oe_q, oe_d;
    logic                 ready_q, ready_d;
    logic                 dv_q, dv_d;
    logic [DW-1:0]        data1_q, data1_d, data2_q, data2_d;
    logic                 otr1_q, otr1_d, otr2_q, otr2_d;
    logic [OTR_CNT_W-1:0] otr1_cnt_q, otr1_cnt_d, otr2_cnt_q, otr2_cnt_d;

    // Pin capture stage: free-running so it can pack into the I/O flops.
    always_ff @(posedge clk_20M) begin
        adc1_r1_q <= adc1_pin;
        adc2_r1_q <= adc2_pin;
        otr1_r1_q <= otr1_pin;
        otr2_r1_q <= otr2_pin;
    end

    always_ff @(posedge clk_20M) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dcnt_q     <= '0;
            oe_q       <= 1'b1;
            ready_q    <= 1'b0;
            dv_q       <= 1'b0;
            data1_q    <= '0;
            data2_q    <= '0;
            otr1_q     <= 1'b0;
            otr2_q     <= 1'b0;
            otr1_cnt_q <= '0;
            otr2_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            oe_q       <= oe_d;
            ready_q    <= ready_d;
            dv_q       <= dv_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            otr1_q     <= otr1_d;
            otr2_q     <= otr2_d;
            otr1_cnt_q <= otr1_cnt_d;
            otr2_cnt_q <= otr2_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WARM;
                    cnt_d   = '0;
                end
                WARM: begin
                    if (cnt_q == WARM_LAST) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                FLUSH: begin
                    if (cnt_q == FLUSH_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        dcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    // decim is only looked at on reload, so mid-period changes wait for the next strobe.
                    dcnt_d = (dcnt_q == '0) ? decim : dcnt_q - DECIM_W'(1);
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    dcnt_d  = '0;
                end
            endcase
        end
    end

    // Outputs are registered against state_d so OE and strobes land on the same edge as the state change.
    always_comb begin
        oe_d       = !((state_d == FLUSH) || (state_d == RUN));
        ready_d    = (state_d == RUN);
        dv_d       = (state_d == RUN) && (dcnt_d == '0);
        data1_d    = data1_q;
        data2_d    = data2_q;
        otr1_d     = otr1_q;
        otr2_d     = otr2_q;
        otr1_cnt_d = otr1_cnt_q;
        otr2_cnt_d = otr2_cnt_q;
        if (dv_d) begin
            data1_d = adc1_r1_q;
            data2_d = adc2_r1_q;
            otr1_d  = otr1_r1_q;
            otr2_d  = otr2_r1_q;
            if (otr1_r1_q && !(&otr1_cnt_q)) begin
                otr1_cnt_d = otr1_cnt_q + OTR_CNT_W'(1);
            end
            if (otr2_r1_q && !(&otr2_cnt_q)) begin
                otr2_cnt_d = otr2_cnt_q + OTR_CNT_W'(1);
            end
        end
        if (otr_clr) begin
            otr1_cnt_d = '0;
            otr2_cnt_d = '0;
        end
    end

    assign ad1oe      = oe_q;
    assign ad2oe      = oe_q;
    assign ad_data1   = data1_q;
    assign ad_data2   = data2_q;
    assign OTR1       = otr1_q;
    assign OTR2       = otr2_q;
    assign data_valid = dv_q;
    assign ready      = ready_q;
    assign otr1_cnt   = otr1_cnt_q;
    assign otr2_cnt   = otr2_cnt_q;

endmodule

// File: tb/tb_ad_dual_capture.sv
// Directed bench for ad_dual_capture with WARMUP_CYC=4, FLUSH_CYC=3, OTR_CNT_W=4.
module tb_ad_dual_capture;

    logic       clk_20M = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] decim = 8'd0;
    logic       otr_clr = 1'b0;
    logic [9:0] adc1_pin = '0;
    logic [9:0] adc2_pin = '0;
    logic       otr1_pin = 1'b0;
    logic       otr2_pin = 1'b0;
    logic       ad1oe, ad2oe;
    logic [9:0] ad_data1, ad_data2;
    logic       OTR1, OTR2, data_valid, ready;
    logic [3:0] otr1_cnt, otr2_cnt;

    ad_dual_capture #(
        .DW(10), .WARMUP_CYC(4), .FLUSH_CYC(3), .DECIM_W(8), .OTR_CNT_W(4)
    ) dut (
        .clk_20M(clk_20M), .rst(rst), .en(en), .decim(decim), .otr_clr(otr_clr),
        .adc1_pin(adc1_pin), .adc2_pin(adc2_pin), .otr1_pin(otr1_pin), .otr2_pin(otr2_pin),
        .ad1oe(ad1oe), .ad2oe(ad2oe), .ad_data1(ad_data1), .ad_data2(ad_data2),
        .OTR1(OTR1), .OTR2(OTR2), .data_valid(data_valid), .ready(ready),
        .otr1_cnt(otr1_cnt), .otr2_cnt(otr2_cnt)
    );

    always #5 clk_20M = ~clk_20M;

    typedef struct {
        logic       en;
        logic [7:0] dec;
        logic [9:0] a1, a2;
        logic       o1, o2;
        logic       oe, rdy, dv;
        logic [9:0] d1, d2;
        logic       q1, q2;
        logic [3:0] c1, c2;
    } vec_t;

    vec_t tbl[21];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk_20M);
        #1;
        cyc++;
    endtask

    task automatic step_ramp();
        adc1_pin = 10'(10 + cyc);
        adc2_pin = 10'(500 + cyc);
        step();
    endtask

    task automatic set_exp(input int i, input logic oe, input logic rdy, input logic dv,
                           input int d1, input int d2, input logic q1, input logic q2,
                           input int c1, input int c2);
        tbl[i].oe = oe; tbl[i].rdy = rdy; tbl[i].dv = dv;
        tbl[i].d1 = 10'(d1); tbl[i].d2 = 10'(d2);
        tbl[i].q1 = q1; tbl[i].q2 = q2;
        tbl[i].c1 = 4'(c1); tbl[i].c2 = 4'(c2);
    endtask

    initial begin
        // Stimulus: ramp pins, OTR1 pulse at cycle 8, OTR2 pulse at 9 (lost to the abort), en low at 10.
        for (int i = 0; i < 21; i++) begin
            tbl[i].en = 1'b1; tbl[i].dec = 8'd0;
            tbl[i].a1 = 10'(10 + i); tbl[i].a2 = 10'(500 + i);
            tbl[i].o1 = 1'b0; tbl[i].o2 = 1'b0;
        end
        tbl[8].o1  = 1'b1;
        tbl[9].o2  = 1'b1;
        tbl[10].en = 1'b0;
        for (int i = 0; i <= 4; i++)   set_exp(i, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 5; i <= 7; i++)   set_exp(i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_exp(8,  0, 1, 1, 16, 506, 0, 0, 0, 0);
        set_exp(9,  0, 1, 1, 17, 507, 0, 0, 0, 0);
        set_exp(10, 0, 1, 1, 18, 508, 1, 0, 1, 0);
        for (int i = 11; i <= 15; i++) set_exp(i, 1, 0, 0, 18, 508, 1, 0, 1, 0);
        for (int i = 16; i <= 18; i++) set_exp(i, 0, 0, 0, 18, 508, 1, 0, 1, 0);
        set_exp(19, 0, 1, 1, 27, 517, 0, 0, 1, 0);
        set_exp(20, 0, 1, 1, 28, 518, 0, 0, 1, 0);

        // Reset with everything driven high.
        rst = 1'b1; en = 1'b1; adc1_pin = 10'h3FF; adc2_pin = 10'h3FF;
        otr1_pin = 1'b1; otr2_pin = 1'b1;
        repeat (3) step();
        chk("rst_ad1oe", ad1oe, 1);      chk("rst_ad2oe", ad2oe, 1);
        chk("rst_data1", ad_data1, 0);   chk("rst_data2", ad_data2, 0);
        chk("rst_otr1", OTR1, 0);        chk("rst_otr2", OTR2, 0);
        chk("rst_dv", data_valid, 0);    chk("rst_ready", ready, 0);
        chk("rst_cnt1", otr1_cnt, 0);    chk("rst_cnt2", otr2_cnt, 0);

        rst = 1'b0; en = 1'b0; otr1_pin = 1'b0; otr2_pin = 1'b0;
        step();
        cyc = 0;

        // Startup, RUN, abort and restart.
        for (int i = 0; i < 21; i++) begin
            chk($sformatf("t%0d_ad1oe", i), ad1oe, tbl[i].oe);
            chk($sformatf("t%0d_ad2oe", i), ad2oe, tbl[i].oe);
            chk($sformatf("t%0d_ready", i), ready, tbl[i].rdy);
            chk($sformatf("t%0d_dv", i), data_valid, tbl[i].dv);
            chk($sformatf("t%0d_data1", i), ad_data1, tbl[i].d1);
            chk($sformatf("t%0d_data2", i), ad_data2, tbl[i].d2);
            chk($sformatf("t%0d_otr1", i), OTR1, tbl[i].q1);
            chk($sformatf("t%0d_otr2", i), OTR2, tbl[i].q2);
            chk($sformatf("t%0d_cnt1", i), otr1_cnt, tbl[i].c1);
            chk($sformatf("t%0d_cnt2", i), otr2_cnt, tbl[i].c2);
            en = tbl[i].en; decim = tbl[i].dec;
            adc1_pin = tbl[i].a1; adc2_pin = tbl[i].a2;
            otr1_pin = tbl[i].o1; otr2_pin = tbl[i].o2;
            step();
        end

        // Decimation by 3 from cycle 21; decim dropped to 0 mid-period at cycle 34.
        decim = 8'd2;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("dec%0d_dv", k), data_valid, (k % 3 == 0) ? 1 : 0);
            chk($sformatf("dec%0d_data1", k), ad_data1, 29 + 3 * (k / 3));
            chk($sformatf("dec%0d_ready", k), ready, 1);
            if (k == 13) decim = 8'd0;
            step_ramp();
        end
        chk("dec_new_dv0", data_valid, 1);
        chk("dec_new_data0", ad_data1, 45);
        step_ramp();
        chk("dec_new_dv1", data_valid, 1);
        chk("dec_new_data1", ad_data1, 46);

        // Clear beats a simultaneous increment, then saturation at 15.
        otr1_pin = 1'b1;
        step_ramp();
        chk("clr_pre_cnt1", otr1_cnt, 1);
        otr_clr = 1'b1;
        step_ramp();
        otr_clr = 1'b0;
        chk("clr_cnt1", otr1_cnt, 0);
        chk("clr_otr1", OTR1, 1);
        chk("clr_dv", data_valid, 1);
        step_ramp();
        chk("clr_next_cnt1", otr1_cnt, 1);
        for (int m = 1; m <= 20; m++) begin
            step_ramp();
            chk($sformatf("sat%0d_cnt1", m), otr1_cnt, (1 + m > 15) ? 15 : 1 + m);
            chk($sformatf("sat%0d_cnt2", m), otr2_cnt, 0);
        end
        otr1_pin = 1'b0;

        // Reset during FLUSH.
        en = 1'b0;
        step_ramp();
        chk("ab_idle_oe", ad1oe, 1);
        chk("ab_idle_cnt1", otr1_cnt, 15);
        en = 1'b1;
        repeat (5) step_ramp();
        chk("ab_flush_oe", ad1oe, 0);
        chk("ab_flush_ready", ready, 0);
        chk("ab_flush_dv", data_valid, 0);
        rst = 1'b1;
        step_ramp();
        chk("ab_rst_ad1oe", ad1oe, 1);
        chk("ab_rst_ad2oe", ad2oe, 1);
        chk("ab_rst_data1", ad_data1, 0);
        chk("ab_rst_cnt1", otr1_cnt, 0);
        chk("ab_rst_ready", ready, 0);
        rst = 1'b0;
        step_ramp();
        chk("ab_warm_oe", ad1oe, 1);
        chk("ab_warm_dv", data_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ad_dual_capture.md
Name: ad_dual_capture

Overview:
Dual-channel ADC front-end that drives the two 10-bit parallel ADCs and captures their outputs.
- Sequences ADC output-enables through warm-up and pipeline flush after enable.
- Registers and aligns both channels' data and out-of-range (OTR) flags.
- Applies optional decimation and keeps saturating OTR event counters.
- Its ad_data1/ad_data2/ad1oe/ad2oe/OTR1/OTR2 outputs feed the downstream processing logic and the on-chip logic-analyser probe on clk_20M.

Parameters:
DW, 10, ADC sample width per channel
WARMUP_CYC, 200, cycles ADC outputs are held disabled after enable (>=1)
FLUSH_CYC, 6, cycles after OE assertion discarded as ADC pipeline latency (>=1)
DECIM_W, 8, width of decimation ratio input
OTR_CNT_W, 16, width of each OTR event counter

Ports:
clk_20M  in  1  system sample clock; all logic on this clock
rst  in  1  synchronous reset, active-high
en  in  1  capture enable
decim  in  DECIM_W  decimation ratio minus one (0 = every cycle)
otr_clr  in  1  clears both OTR counters
adc1_pin  in  DW  ADC1 data pins, offset binary
adc2_pin  in  DW  ADC2 data pins
otr1_pin  in  1  ADC1 out-of-range pin
otr2_pin  in  1  ADC2 out-of-range pin
ad1oe  out  1  ADC1 output enable, active-low (1 = tri-stated)
ad2oe  out  1  ADC2 output enable, active-low
ad_data1  out  DW  captured ADC1 sample
ad_data2  out  DW  captured ADC2 sample
OTR1  out  1  OTR flag aligned with ad_data1
OTR2  out  1  OTR flag aligned with ad_data2
data_valid  out  1  one-cycle strobe: new sample on ad_data*/OTR*
ready  out  1  high while in RUN
otr1_cnt  out  OTR_CNT_W  count of valid samples with OTR1 set
otr2_cnt  out  OTR_CNT_W  count of valid samples with OTR2 set

Behaviour:
Reset (rst=1 at clock edge) — all outputs registered:
- state=IDLE, ad1oe=ad2oe=1, ad_data*=0, OTR*=0, data_valid=0, ready=0, otr*_cnt=0, counters=0.

Input stage:
- adc*_pin and otr*_pin registered every cycle into r1 (IOB flops), regardless of state.

FSM (single counter shared by WARM and FLUSH):
- IDLE: oe=1. en=1 -> WARM, cnt=0.
- WARM: oe=1; cnt increments. At cnt==WARMUP_CYC-1 -> FLUSH, cnt=0. Lasts exactly WARMUP_CYC cycles.
- FLUSH: oe=0; no data_valid. At cnt==FLUSH_CYC-1 -> RUN, dcnt=0. Lasts exactly FLUSH_CYC cycles.
- RUN: oe=0, ready=1.
- en=0 in any non-IDLE state -> IDLE next cycle: oe=1, ready=0, data_valid=0. ad_data*/OTR* hold their last values.
- ad1oe and ad2oe always switch together, on the same edge as the state change.

Decimation (RUN only):
- Each cycle: if dcnt==0 then data_valid=1 and dcnt<=decim; else data_valid=0 and dcnt<=dcnt-1.
- Strobes therefore occur on RUN cycles 0, decim+1, 2(decim+1), …
- decim is sampled only at each reload; changes mid-period take effect after the next strobe.

Data path:
- On data_valid cycles ad_data*/OTR* load from r1. Otherwise they hold.
- Pin-to-output latency: 2 cycles. data_valid is asserted in the same cycle the new value is visible.

OTR counters:
- On each data_valid with the corresponding r1 OTR=1: count +1, saturating at all-ones (no wrap).
- otr_clr=1 forces both counters to 0; clear wins over a simultaneous increment.
- Counters are not cleared by en toggling, only by rst or otr_clr.

Reset mid-operation:
- rst in any state returns to reset values on the next edge, including oe=1.
- rst has priority over en.

Test Plan:
- Reset values: assert rst 3 cycles with en=1, pins=0x3FF -> all outputs at reset values, ad1oe=ad2oe=1.
- Startup timing (WARMUP_CYC=4, FLUSH_CYC=3, decim=0): en rises at cycle 0 -> WARM cycles 1–4 with oe=1; oe=0 from cycle 5; FLUSH cycles 5–7 with no valid; ready=1 and data_valid=1 from cycle 8. Pins driven with a cycle counter -> ad_data1 at cycle 8 equals pin value from cycle 6.
- Decimation: decim=2, ramp pins -> data_valid every 3rd RUN cycle; ad_data1 steps by 3 each strobe and holds between strobes.
- OTR saturation (OTR_CNT_W=4): otr1_pin=1 for 20 valid samples -> otr1_cnt reaches 15 and stays; otr2_cnt=0.
- Clear vs increment: otr_clr=1 on a strobe with OTR1=1 -> otr1_cnt=0 next cycle; next strobe with OTR1=1 -> 1.
- Abort paths:
  - en=0 mid-RUN -> next cycle IDLE, oe=1, data_valid=0, ad_data held; en=1 again -> full WARM+FLUSH sequence repeats.
  - rst during FLUSH -> oe=1 next edge.
